// File: rtl/mdio_master.sv
// Clause 22 MDIO management master. It takes one read or write command at a
// time, serialises the frame onto the MDIO pads, and returns the read data
// together with a no-PHY flag.
`timescale 1ns/1ps
module mdio_master #(
  parameter int unsigned CLK_DIV     = 25,   // msoc_clk cycles per MDC half-period (2..255)
  parameter bit          PREAMBLE_EN = 1'b1  // 1 = send the 32-bit all-ones preamble
) (
  input  logic        msoc_clk,
  input  logic        rst_int,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  input  logic        phy_mdio_i,
  output logic        phy_mdio_o,
  output logic        phy_mdio_oen,
  output logic        phy_mdc
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_TA   = 3'd3,
    ST_DATA = 3'd4,
    ST_END  = 3'd5
  } state_t;

  // Last count of one MDC half-period.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_r;
  logic [7:0]  div_r;        // cycles elapsed in the current MDC half-period
  logic [5:0]  bit_cnt_r;    // bit index inside the current frame field
  logic        write_r;      // captured command direction
  logic [13:0] hdr_sr_r;     // ST, OP, PHYAD, REGAD; MSB goes out first
  logic [15:0] data_sr_r;    // write data out, or read data shifted in
  logic        ta_err_r;     // second turnaround sample of a read
  logic        mdc_r;
  logic        mdio_o_r;
  logic        mdio_oen_r;
  logic        cmd_ready_r;
  logic        busy_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic        half_done_s;

  // A half-period ends on the last divider count; MDC toggles on the next edge.
  always_comb begin
    half_done_s = (div_r == DIV_LAST);
  end

  // Frame sequencer: divider, MDC generation, pad drive, sampling and response.
  always_ff @(posedge msoc_clk) begin
    if (rst_int) begin
      state_r     <= ST_IDLE;
      div_r       <= 8'd0;
      bit_cnt_r   <= 6'd0;
      write_r     <= 1'b0;
      hdr_sr_r    <= 14'd0;
      data_sr_r   <= 16'd0;
      ta_err_r    <= 1'b0;
      mdc_r       <= 1'b0;
      mdio_o_r    <= 1'b0;
      mdio_oen_r  <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 16'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          mdc_r <= 1'b0;
          div_r <= 8'd0;
          if (cmd_valid && cmd_ready_r) begin
            // Capture the whole command now; later input changes are ignored.
            write_r     <= cmd_write;
            hdr_sr_r    <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr};
            data_sr_r   <= cmd_wdata;
            bit_cnt_r   <= 6'd0;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            mdio_oen_r  <= 1'b1;
            if (PREAMBLE_EN) begin
              state_r  <= ST_PRE;
              mdio_o_r <= 1'b1;
            end else begin
              // First header bit is the leading 0 of the start code.
              state_r  <= ST_HDR;
              mdio_o_r <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_PRE, ST_HDR, ST_TA, ST_DATA, ST_END: begin
          if (!half_done_s) begin
            div_r <= div_r + 8'd1;
          end else if (!mdc_r) begin
            // MDC rising edge: the PHY's driven value is sampled here.
            div_r <= 8'd0;
            mdc_r <= 1'b1;
            if (!write_r && (state_r == ST_TA) && (bit_cnt_r == 6'd1)) begin
              ta_err_r <= phy_mdio_i;
            end else if (!write_r && (state_r == ST_DATA)) begin
              data_sr_r <= {data_sr_r[14:0], phy_mdio_i};
            end else begin
              ta_err_r <= ta_err_r;
            end
          end else begin
            // MDC falling edge: end of this bit, launch the next one.
            div_r <= 8'd0;
            mdc_r <= 1'b0;
            case (state_r)
              ST_PRE: begin
                if (bit_cnt_r == 6'd31) begin
                  state_r   <= ST_HDR;
                  bit_cnt_r <= 6'd0;
                  mdio_o_r  <= hdr_sr_r[13];
                end else begin
                  bit_cnt_r <= bit_cnt_r + 6'd1;
                  mdio_o_r  <= 1'b1;
                end
              end
              ST_HDR: begin
                if (bit_cnt_r == 6'd13) begin
                  // Turnaround: a write drives 1,0; a read releases the pad.
                  state_r    <= ST_TA;
                  bit_cnt_r  <= 6'd0;
                  mdio_o_r   <= write_r;
                  mdio_oen_r <= write_r;
                end else begin
                  bit_cnt_r <= bit_cnt_r + 6'd1;
                  hdr_sr_r  <= {hdr_sr_r[12:0], 1'b0};
                  mdio_o_r  <= hdr_sr_r[12];
                end
              end
              ST_TA: begin
                if (bit_cnt_r == 6'd1) begin
                  state_r    <= ST_DATA;
                  bit_cnt_r  <= 6'd0;
                  mdio_o_r   <= write_r & data_sr_r[15];
                  mdio_oen_r <= write_r;
                end else begin
                  bit_cnt_r <= 6'd1;
                  mdio_o_r  <= 1'b0;
                end
              end
              ST_DATA: begin
                if (bit_cnt_r == 6'd15) begin
                  // Release bit before returning to idle.
                  state_r    <= ST_END;
                  bit_cnt_r  <= 6'd0;
                  mdio_o_r   <= 1'b0;
                  mdio_oen_r <= 1'b0;
                end else if (write_r) begin
                  bit_cnt_r <= bit_cnt_r + 6'd1;
                  data_sr_r <= {data_sr_r[14:0], 1'b0};
                  mdio_o_r  <= data_sr_r[14];
                end else begin
                  bit_cnt_r <= bit_cnt_r + 6'd1;
                  mdio_o_r  <= 1'b0;
                end
              end
              ST_END: begin
                // busy stays high through the response cycle; IDLE clears it.
                state_r     <= ST_IDLE;
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= write_r ? 16'd0 : data_sr_r;
                rsp_err_r   <= write_r ? 1'b0 : ta_err_r;
                cmd_ready_r <= 1'b1;
                mdio_o_r    <= 1'b0;
                mdio_oen_r  <= 1'b0;
              end
              default: begin
                state_r     <= ST_IDLE;
                cmd_ready_r <= 1'b1;
                mdio_o_r    <= 1'b0;
                mdio_oen_r  <= 1'b0;
              end
            endcase
          end
        end

        default: begin
          // Unreachable encoding: return quietly to idle with pads released.
          state_r     <= ST_IDLE;
          div_r       <= 8'd0;
          bit_cnt_r   <= 6'd0;
          mdc_r       <= 1'b0;
          mdio_o_r    <= 1'b0;
          mdio_oen_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign busy         = busy_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign rsp_err      = rsp_err_r;
  assign phy_mdc      = mdc_r;
  assign phy_mdio_o   = mdio_o_r;
  assign phy_mdio_oen = mdio_oen_r;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master (CLK_DIV=2): stimulus pushes expected
// responses, monitors pop and compare on rsp_valid. A second instance
// without preamble covers the short frame.
`timescale 1ns/1ps
module tb_mdio_master;

  logic        msoc_clk = 1'b0;
  logic        rst_int;
  logic        cmd_valid, cmd_write;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic        phy_mdio_i, phy_mdio_o, phy_mdio_oen, phy_mdc;

  logic        np_cmd_valid, np_cmd_write;
  logic [4:0]  np_cmd_phy_addr, np_cmd_reg_addr;
  logic [15:0] np_cmd_wdata;
  logic        np_cmd_ready, np_rsp_valid, np_rsp_err, np_busy;
  logic [15:0] np_rsp_rdata;
  logic        np_phy_mdio_i, np_phy_mdio_o, np_phy_mdio_oen, np_phy_mdc;

  always #5 msoc_clk = ~msoc_clk;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_EN(1'b1)) dut (
    .msoc_clk(msoc_clk), .rst_int(rst_int),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .phy_mdio_i(phy_mdio_i), .phy_mdio_o(phy_mdio_o), .phy_mdio_oen(phy_mdio_oen),
    .phy_mdc(phy_mdc)
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_EN(1'b0)) dut_np (
    .msoc_clk(msoc_clk), .rst_int(rst_int),
    .cmd_valid(np_cmd_valid), .cmd_ready(np_cmd_ready), .cmd_write(np_cmd_write),
    .cmd_phy_addr(np_cmd_phy_addr), .cmd_reg_addr(np_cmd_reg_addr), .cmd_wdata(np_cmd_wdata),
    .rsp_valid(np_rsp_valid), .rsp_rdata(np_rsp_rdata), .rsp_err(np_rsp_err), .busy(np_busy),
    .phy_mdio_i(np_phy_mdio_i), .phy_mdio_o(np_phy_mdio_o), .phy_mdio_oen(np_phy_mdio_oen),
    .phy_mdc(np_phy_mdc)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { logic [15:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   acc_cnt = 0, rsp_cnt = 0, last_acc_cyc = 0, last_rsp_cyc = 0;

  // Posedge counter used to time accept-to-response latency.
  always @(posedge msoc_clk) cyc <= cyc + 1;

  // Accept monitor: accept happens on the next posedge.
  always @(negedge msoc_clk) begin
    if (!rst_int && cmd_valid && cmd_ready) begin
      acc_q.push_back(cyc + 1);
      acc_cnt++;
      last_acc_cyc = cyc + 1;
    end
  end

  // Response monitor: pops the expectation and the accept time.
  always @(negedge msoc_clk) begin
    if (!rst_int && rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check("rsp_expected", (exp_q.size() > 0 && acc_q.size() > 0), 1'b1);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("rsp_latency", cyc - a, 260);
      end
    end
  end

  // ---------------- PHY model and pad recorder ----------------
  int          phy_mode = 0;      // 0 = nothing attached (pull-up), 1 = responding PHY
  logic [15:0] phy_data = 16'h0;
  int          rise_cnt = 0;
  logic        prev_mdc = 1'b0;
  logic [64:0] got_o, got_oen;    // bit 64 = first frame bit

  function automatic logic phy_val(input int b);
    if (phy_mode == 0) return 1'b1;
    if (b == 47) return 1'b0;
    if (b >= 48 && b <= 63) return phy_data[63 - b];
    return 1'b1;
  endfunction

  // Records pad state at each MDC rise and drives the PHY answer for the next bit.
  always @(negedge msoc_clk) begin
    if (rst_int || !busy || rsp_valid) begin
      rise_cnt = 0;
    end else if (phy_mdc && !prev_mdc) begin
      if (rise_cnt < 65) begin
        int idx;
        idx = 64 - rise_cnt;
        got_o[idx]   = phy_mdio_o;
        got_oen[idx] = phy_mdio_oen;
      end
      rise_cnt++;
    end
    prev_mdc   = phy_mdc;
    phy_mdio_i = phy_val(rise_cnt);
  end

  int         np_rise_cnt = 0;
  logic       np_prev_mdc = 1'b0;
  logic [3:0] np_bits = 4'h0;

  // First four sampled bits of the no-preamble instance.
  always @(negedge msoc_clk) begin
    if (rst_int || !np_busy || np_rsp_valid) begin
      np_rise_cnt = 0;
    end else if (np_phy_mdc && !np_prev_mdc) begin
      if (np_rise_cnt < 4) np_bits[3 - np_rise_cnt] = np_phy_mdio_o;
      np_rise_cnt++;
    end
    np_prev_mdc = np_phy_mdc;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic [15:0] er, input logic ee,
                       input bit expect_rsp);
    bit ok;
    if (expect_rsp) exp_q.push_back('{er, ee});
    @(posedge msoc_clk); #2;
    cmd_write = w; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge msoc_clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", ok, 1'b1);
    @(posedge msoc_clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge msoc_clk);
      if (rsp_cnt >= target) begin ok = 1'b1; break; end
    end
    if (!ok) check("rsp_timeout", ok, 1'b1);
  endtask

  task automatic check_reset_state(input string name);
    check(name, {cmd_ready, busy, rsp_valid, rsp_rdata, rsp_err, phy_mdc, phy_mdio_o, phy_mdio_oen},
          {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          bad, base, base_acc, rsp1, acc2, lat;
    logic [64:0] exp_o, exp_oen;

    rst_int = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_phy_addr = 5'd0; cmd_reg_addr = 5'd0; cmd_wdata = 16'h0;
    np_cmd_valid = 1'b0; np_cmd_write = 1'b0; np_cmd_phy_addr = 5'd0;
    np_cmd_reg_addr = 5'd0; np_cmd_wdata = 16'h0; np_phy_mdio_i = 1'b1;
    phy_mdio_i = 1'b1;

    // 1. reset and idle
    repeat (3) @(posedge msoc_clk);
    #2 rst_int = 1'b0;
    @(negedge msoc_clk);
    check_reset_state("reset_state");
    bad = 0;
    repeat (100) begin
      @(negedge msoc_clk);
      if (phy_mdc !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    check("idle_mdc_ready", bad, 0);

    // 2. write PHY 1 reg 0 data 0x1140
    base = rsp_cnt;
    issue(1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, 1'b1);
    wait_rsp(base + 1);
    exp_o   = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140, 1'b0};
    exp_oen = {{64{1'b1}}, 1'b0};
    check("wr_mdio_bits", got_o, exp_o);
    check("wr_mdio_oen", got_oen, exp_oen);

    // 3. read PHY 3 reg 2, PHY answers 0x796D
    phy_mode = 1; phy_data = 16'h796D;
    base = rsp_cnt;
    issue(1'b0, 5'd3, 5'd2, 16'h0000, 16'h796D, 1'b0, 1'b1);
    wait_rsp(base + 1);
    exp_oen = {{46{1'b1}}, {19{1'b0}}};
    exp_o   = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd2, 19'd0};
    check("rd_mdio_oen", got_oen, exp_oen);
    check("rd_mdio_hdr_bits", got_o & exp_oen, exp_o);

    // 4. read with no PHY
    phy_mode = 0;
    base = rsp_cnt;
    issue(1'b0, 5'd7, 5'd1, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    wait_rsp(base + 1);

    // 5. back-to-back with cmd_valid held, plus ignored mid-frame pulses
    phy_mode = 1; phy_data = 16'hA5C3;
    base = rsp_cnt; base_acc = acc_cnt;
    exp_q.push_back('{16'h0000, 1'b0});
    exp_q.push_back('{16'hA5C3, 1'b0});
    @(posedge msoc_clk); #2;
    cmd_write = 1'b1; cmd_phy_addr = 5'd2; cmd_reg_addr = 5'd9; cmd_wdata = 16'h0F0F; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge msoc_clk); #2;
      if (acc_cnt >= base_acc + 1) break;
    end
    cmd_write = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge msoc_clk); #2;
      if (acc_cnt >= base_acc + 2) break;
    end
    cmd_valid = 1'b0;
    rsp1 = last_rsp_cyc; acc2 = last_acc_cyc;
    check("b2b_accept_in_rsp_cycle", acc2, rsp1 + 1);
    repeat (40) @(posedge msoc_clk);
    #2 cmd_write = 1'b1; cmd_phy_addr = 5'd31; cmd_reg_addr = 5'd31; cmd_wdata = 16'h1234; cmd_valid = 1'b1;
    repeat (3) @(posedge msoc_clk);
    #2 cmd_valid = 1'b0;
    wait_rsp(base + 2);
    check("b2b_accept_count", acc_cnt - base_acc, 2);

    // 6a. reset during DATA of a write
    phy_mode = 0;
    base = rsp_cnt;
    issue(1'b1, 5'd4, 5'd5, 16'hCAFE, 16'h0000, 1'b0, 1'b0);
    repeat (200) @(posedge msoc_clk);
    #2 rst_int = 1'b1;
    @(posedge msoc_clk);
    #2 rst_int = 1'b0;
    acc_q.delete();
    @(negedge msoc_clk);
    check_reset_state("midframe_reset_state");
    repeat (300) @(posedge msoc_clk);
    check("no_rsp_after_abort", rsp_cnt, base);
    issue(1'b1, 5'd4, 5'd5, 16'hCAFE, 16'h0000, 1'b0, 1'b1);
    wait_rsp(base + 1);

    // 6b. no preamble: 132-cycle write, frame starts 0101
    @(posedge msoc_clk); #2;
    np_cmd_write = 1'b1; np_cmd_phy_addr = 5'd2; np_cmd_reg_addr = 5'd4; np_cmd_wdata = 16'hBEEF;
    np_cmd_valid = 1'b1;
    @(negedge msoc_clk);
    check("np_cmd_ready", np_cmd_ready, 1'b1);
    @(posedge msoc_clk); #2;
    np_cmd_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge msoc_clk);
      @(negedge msoc_clk);
      if (np_rsp_valid) begin lat = k; break; end
    end
    check("np_latency", lat, 132);
    check("np_first_bits", np_bits, 4'b0101);
    check("np_rsp", {np_rsp_rdata, np_rsp_err}, 17'd0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Hardware MDIO (IEEE 802.3 clause 22) management controller for the RGMII PHY.
- Replaces software bit-banging of phy_mdc/phy_mdio_o/phy_mdio_oen through the framing register block.
- Accepts one read or write command at a time from the register interface, serialises the management frame, and returns read data plus a no-PHY error flag.
- Sits in the msoc_clk domain beside the framing registers; its outputs drive the PHY MDIO pads directly.

Parameters:
- CLK_DIV, 25, msoc_clk cycles per MDC half-period (MDC = msoc_clk/(2*CLK_DIV)); legal range 2..255.
- PREAMBLE_EN, 1, 1 = send 32-bit all-ones preamble; 0 = suppress preamble.

Ports:
- msoc_clk  in  1  sole clock
- rst_int  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_phy_addr  in  5  PHY address
- cmd_reg_addr  in  5  register address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data; 0 for writes
- rsp_err  out  1  read turnaround bit sampled as 1 (no PHY); 0 for writes
- busy  out  1  frame in progress
- phy_mdio_i  in  1  MDIO pad input
- phy_mdio_o  out  1  MDIO pad output value
- phy_mdio_oen  out  1  1 = controller drives MDIO pad
- phy_mdc  out  1  management clock

Behaviour:
- Clock and reset: msoc_clk is the only clock. rst_int is synchronous and active-high.
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, phy_mdc=0, phy_mdio_o=0, phy_mdio_oen=0, FSM=IDLE, divider=0.
- Reset mid-frame aborts the frame with no rsp_valid; pads return to reset values on the next edge.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - Accept occurs on the edge where cmd_valid & cmd_ready; all cmd_* fields are captured then, and later changes are ignored.
  - busy=1 from the cycle after accept until the rsp_valid cycle inclusive.
- Bit timing:
  - Each bit lasts 2*CLK_DIV cycles: CLK_DIV cycles with phy_mdc=0, then CLK_DIV cycles with phy_mdc=1.
  - phy_mdio_o/phy_mdio_oen update at each bit start (MDC falling edge).
  - phy_mdio_i is captured on the msoc_clk edge at which phy_mdc goes 0->1.
  - In IDLE, phy_mdc is held at 0.
- FSM, with bit counts:
  - IDLE -> PRE on accept if PREAMBLE_EN, else IDLE -> HDR.
  - PRE (32): phy_mdio_o=1, oen=1.
  - HDR (14), MSB first: ST=01, OP (write=01, read=10), PHYAD[4:0], REGAD[4:0]; oen=1.
  - TA (2):
    - write: drive 1 then 0, oen=1.
    - read: oen=0 for both bits; the second TA sample is the error flag (1 -> rsp_err=1).
  - DATA (16), MSB first:
    - write: drive cmd_wdata, oen=1.
    - read: oen=0, shift in samples.
  - END (1): oen=0, phy_mdio_o=0 (idle/release bit).
  - Then IDLE.
- Completion:
  - In the first IDLE cycle after END: rsp_valid=1 for exactly one cycle, with rsp_rdata/rsp_err valid.
  - cmd_ready=1 in that same cycle, so back-to-back accept is permitted.
  - rsp_rdata/rsp_err hold until the next completion.
- Latency from the accept edge to rsp_valid is exactly N*2*CLK_DIV cycles:
  - PREAMBLE_EN=1: N=65.
  - PREAMBLE_EN=0: N=33.
- A failed read (rsp_err=1) still completes the full frame and returns the captured data (typically 0xFFFF via pull-up).
- Divider counter width is 8 bits; bit counter width is 6 bits. Neither wraps within a legal frame.
- cmd_valid while busy is ignored; there is no queueing.

Test Plan (CLK_DIV=2, PREAMBLE_EN=1 unless noted):
1. Reset: hold rst_int 3 cycles, then check all outputs at their reset values; cmd_ready=1, phy_mdc stays 0 for 100 idle cycles.
2. Write PHY 1, reg 0, data 0x1140:
   - MDIO bits sampled at MDC rise are 32x'1', then 0101 00001 00000 10 0001000101000000, then released.
   - oen=0 only in END.
   - rsp_valid arrives exactly 260 cycles after accept with rsp_rdata=0, rsp_err=0.
3. Read PHY 3, reg 2, with a PHY model that drives TA bit 2 = 0 and data 0x796D:
   - oen=0 during TA/DATA/END.
   - Response is rsp_rdata=0x796D, rsp_err=0 at cycle 260.
4. Read with phy_mdio_i tied to 1 (no PHY) -> rsp_rdata=0xFFFF, rsp_err=1, with full frame timing.
5. Back-to-back:
   - Hold cmd_valid high with a write then a read; the second accept lands in the rsp_valid cycle.
   - The second rsp_valid arrives 260 cycles later.
   - cmd_valid pulses mid-frame are ignored.
6. Reset and preamble suppression:
   - Assert rst_int during DATA of a write: no rsp_valid, next cycle is in reset state, a new command completes normally.
   - With PREAMBLE_EN=0, a write completes in 132 cycles and the first MDIO bits are 0101.
